// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble binary to packed BCD converter.
//
// Each conversion takes one cycle per input bit and ends with a one-cycle
// DONE state. Values above the display range saturate to all nines.
//
// Ports:
//   i_clk       clock, all state changes on the rising edge
//   i_rst       synchronous reset, active low
//   i_bin       unsigned binary value, latched when a start is accepted
//   i_start     conversion request, only looked at in IDLE
//   o_bcd_data  registered packed BCD result, most significant digit on top
//   o_busy      high while shifting
//   o_done      one-cycle pulse when o_bcd_data has just been loaded
//   o_overflow  set when the last converted value saturated the display
//
// state   | meaning
// S_IDLE  | waiting for i_start; outputs hold
// S_SHIFT | one add-3 and shift step per cycle, BIN_WIDTH cycles in total
// S_DONE  | result just loaded, o_done high for this single cycle
module bin_to_bcd #(
   parameter int DISPLAYS_NUM = 4,
   parameter int BIN_WIDTH    = 14
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [BIN_WIDTH-1:0]      i_bin,
   input  logic                      i_start,
   output logic [DISPLAYS_NUM*4-1:0] o_bcd_data,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_overflow
);

   // Decimal digits needed to hold 2^w - 1.
   function automatic int dec_digits(input int w);
      longint unsigned v;
      int              n;
      v = (64'd1 << w) - 64'd1;
      n = 1;
      while (v >= 64'd10) begin
         v = v / 64'd10;
         n = n + 1;
      end
      return n;
   endfunction

   localparam int ACC_DIGITS = dec_digits(BIN_WIDTH);
   localparam int ACC_W      = ACC_DIGITS * 4;
   localparam int OUT_W      = DISPLAYS_NUM * 4;
   // Room for both the accumulator and the display width, plus one spare
   // digit so the overflow shift below is always well defined.
   localparam int EXT_W      = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 4;
   localparam int CNT_W      = $clog2(BIN_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                 state_q;
   logic [BIN_WIDTH-1:0]   sr_q;
   logic [ACC_W-1:0]       acc_q;
   logic [CNT_W-1:0]       cnt_q;

   logic [ACC_W-1:0]           acc_adj_d;
   logic [ACC_W+BIN_WIDTH-1:0] cat_d;
   logic [ACC_W-1:0]           acc_d;
   logic [BIN_WIDTH-1:0]       sr_d;
   logic [EXT_W-1:0]           ext_d;
   logic                       ovf_d;
   logic [OUT_W-1:0]           bcd_d;

   always_comb begin
      acc_adj_d = acc_q;
      for (int d = 0; d < ACC_DIGITS; d++) begin
         if (acc_q[d*4 +: 4] >= 4'd5)
            acc_adj_d[d*4 +: 4] = acc_q[d*4 +: 4] + 4'd3;
      end
      cat_d = {acc_adj_d, sr_q} << 1;
      acc_d = cat_d[ACC_W+BIN_WIDTH-1:BIN_WIDTH];
      sr_d  = cat_d[BIN_WIDTH-1:0];
      // The final accumulator is only known combinationally on the last
      // shift edge, so the result and overflow are taken from acc_d there.
      ext_d = EXT_W'(acc_d);
      ovf_d = |(ext_d >> OUT_W);
      bcd_d = ovf_d ? {DISPLAYS_NUM{4'h9}} : ext_d[OUT_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= S_IDLE;
         sr_q       <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         o_bcd_data <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  sr_q    <= i_bin;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= S_SHIFT;
                  o_busy  <= 1'b1;
               end
            end
            S_SHIFT: begin
               acc_q <= acc_d;
               sr_q  <= sr_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                  state_q    <= S_DONE;
                  o_busy     <= 1'b0;
                  o_done     <= 1'b1;
                  o_bcd_data <= bcd_d;
                  o_overflow <= ovf_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               o_done  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd (BIN_WIDTH=14, DISPLAYS_NUM=4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Edge E0 accepts the start; the DONE cycle is the one that follows
// the last of the 14 shift edges, i.e. o_done is seen before edge E0+15.
module tb_bin_to_bcd;

   logic        clk;
   logic        rst;
   logic [13:0] bin;
   logic        start;
   logic [15:0] bcd;
   logic        busy;
   logic        done;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   bin_to_bcd #(.DISPLAYS_NUM(4), .BIN_WIDTH(14)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_bin      (bin),
      .i_start    (start),
      .o_bcd_data (bcd),
      .o_busy     (busy),
      .o_done     (done),
      .o_overflow (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits by division, saturating above 9999.
   function automatic logic [15:0] bcd_ref(input int v);
      logic [15:0] r;
      int          t;
      if (v > 9999) return 16'h9999;
      r = '0;
      t = v;
      for (int d = 0; d < 4; d++) begin
         r[d*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // One full conversion from IDLE; leaves the DUT back in IDLE.
   task automatic conv(input int v, input string tag);
      int n;
      bin   = 14'(v);
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         step();
      end
      chk({tag, "_busy_len"}, n, 14);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_bcd"}, bcd, bcd_ref(v));
      chk({tag, "_ovf"}, ovf, (v > 9999) ? 1 : 0);
      step();
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   int          n;
   int          cnt;
   logic [15:0] held;
   int          sweep_vals[$];

   initial begin
      rst   = 1'b0;
      bin   = '0;
      start = 1'b0;
      step();
      step();
      chk("rst_bcd", bcd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);

      // Start accepted at the first edge after reset release.
      rst   = 1'b1;
      bin   = 14'd1234;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("first_start_busy", busy, 1);
      n = 1;
      while (busy && n < 40) begin
         chk("busy_no_done", done, 0);
         n++;
         step();
      end
      chk("1234_busy_len", n, 15);
      chk("1234_done", done, 1);
      chk("1234_bcd", bcd, 16'h1234);
      chk("1234_ovf", ovf, 0);
      step();
      chk("1234_done_low", done, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_hold_bcd", bcd, 16'h1234);
      end

      conv(9999, "c9999");
      conv(10000, "c10000");
      held = bcd;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ovf_hold", ovf, 1);
         chk("ovf_hold_bcd", bcd, 16'h9999);
      end
      conv(0, "c0");

      // Start pulses during SHIFT and DONE, input changed mid-conversion.
      bin   = 14'd321;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      bin   = 14'd999;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         n++;
         step();
      end
      chk("ignore_done", done, 1);
      chk("ignore_bcd", bcd, 16'h0321);
      start = 1'b1;
      step();
      start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (done || busy) cnt++;
         step();
      end
      chk("ignore_no_requeue", cnt, 0);
      chk("ignore_bcd_hold", bcd, 16'h0321);

      // Start held high: one conversion per 16 cycles.
      bin   = 14'd16383;
      start = 1'b1;
      n = 0;
      while (!done && n < 40) begin
         n++;
         step();
      end
      chk("b2b_first_done", done, 1);
      for (int k = 0; k < 3; k++) begin
         n = 0;
         step();
         n++;
         while (!done && n < 40) begin
            n++;
            step();
         end
         chk("b2b_period", n, 16);
         chk("b2b_bcd", bcd, 16'h9999);
         chk("b2b_ovf", ovf, 1);
      end
      start = 1'b0;
      n = 0;
      while ((busy || done) && n < 40) begin
         n++;
         step();
      end
      chk("b2b_drained", busy | done, 0);

      // Reset at shift cycle 7 aborts the conversion.
      bin   = 14'd1234;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("abort_busy_before", busy, 1);
      rst = 1'b0;
      step();
      chk("abort_bcd", bcd, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_ovf", ovf, 0);
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy) cnt++;
         step();
      end
      chk("abort_no_done", cnt, 0);
      conv(42, "c42");
      chk("c42_value", bcd, 16'h0042);

      // Strided sweep plus decimal boundaries.
      for (int v = 0; v < 16384; v += 97) sweep_vals.push_back(v);
      sweep_vals.push_back(1);
      sweep_vals.push_back(9);
      sweep_vals.push_back(10);
      sweep_vals.push_back(99);
      sweep_vals.push_back(100);
      sweep_vals.push_back(999);
      sweep_vals.push_back(1000);
      sweep_vals.push_back(9998);
      sweep_vals.push_back(10001);
      sweep_vals.push_back(8191);
      sweep_vals.push_back(8192);
      sweep_vals.push_back(16383);
      foreach (sweep_vals[i]) conv(sweep_vals[i], "sweep");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
